// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Shares the single write port of the register file between two writeback
// requesters (for example ALU result and memory load). A one-bit round-robin
// pointer picks the winner when both request in the same cycle. The winning
// write is registered before it drives the register file. A combinational
// hazard flag tells the sequencer when a read address matches a write that has
// not yet retired.
//
// Ports
//   Clk            system clock, rising edge
//   Rst_n          asynchronous active-low reset
//   Req0/Addr0/Data0, Ack0   requester 0 handshake (Ack0 is combinational)
//   Req1/Addr1/Data1, Ack1   requester 1 handshake (Ack1 is combinational)
//   Hold           blocks new grants while high
//   Ard1, Ard2     register file read addresses, used only for the hazard check
//   Awr, Din, WrEn registered write port that drives the register file
//   Hazard         a read address matches an in-flight write (combinational)
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] Data0,
  output logic          Ack0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Data1,
  output logic          Ack1,
  input  logic          Hold,
  input  logic [AW-1:0] Ard1,
  input  logic [AW-1:0] Ard2,
  output logic [AW-1:0] Awr,
  output logic [DW-1:0] Din,
  output logic          WrEn,
  output logic          Hazard
);

  // Index of the requester favoured when both request together.
  logic prio;
  logic xfer;

  logic hit_wr;
  logic hit_req0;
  logic hit_req1;

  // Grant: requester 0 wins when it is alone or when it holds priority;
  // otherwise requester 1 wins whenever it asks. Hold blocks both.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    Ack0 = 1'b0;
    Ack1 = 1'b0;
    if (!Hold) begin
      if (Req0 && (!Req1 || !prio)) begin
        Ack0 = 1'b1;
      end else if (Req1) begin
        Ack1 = 1'b1;
      end
    end
  end

  assign xfer = Ack0 | Ack1;

  // Output register and priority pointer. On a transfer the pointer moves to
  // the requester that did not win, which is simply Ack0 (winner 0 -> 1,
  // winner 1 -> 0). Awr/Din keep their last values when idle so the register
  // file address stays stable.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      WrEn <= 1'b0;
      Awr  <= '0;
      Din  <= '0;
      prio <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      WrEn <= xfer;
      if (xfer) begin
        Awr  <= Ack0 ? Addr0 : Addr1;
        Din  <= Ack0 ? Data0 : Data1;
        prio <= Ack0;
      end
    end
  end

  // A read address collides with the registered write, or with either
  // requester's pending destination. Address 0 gets no special treatment.
  assign hit_wr   = WrEn && ((Awr   == Ard1) || (Awr   == Ard2));
  assign hit_req0 = Req0 && ((Addr0 == Ard1) || (Addr0 == Ard2));
  assign hit_req1 = Req1 && ((Addr1 == Ard1) || (Addr1 == Ard2));

  assign Hazard = hit_wr | hit_req0 | hit_req1;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Self-checking bench: a reset sequence, a table of per-cycle vectors with
// hand-derived expectations, a mid-write asynchronous reset sequence, and a
// randomized run checked against a behavioural model of the arbiter.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk;
  logic          Rst_n;
  logic          Req0;
  logic [AW-1:0] Addr0;
  logic [DW-1:0] Data0;
  logic          Ack0;
  logic          Req1;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] Data1;
  logic          Ack1;
  logic          Hold;
  logic [AW-1:0] Ard1;
  logic [AW-1:0] Ard2;
  logic [AW-1:0] Awr;
  logic [DW-1:0] Din;
  logic          WrEn;
  logic          Hazard;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Req0   (Req0),
    .Addr0  (Addr0),
    .Data0  (Data0),
    .Ack0   (Ack0),
    .Req1   (Req1),
    .Addr1  (Addr1),
    .Data1  (Data1),
    .Ack1   (Ack1),
    .Hold   (Hold),
    .Ard1   (Ard1),
    .Ard2   (Ard2),
    .Awr    (Awr),
    .Din    (Din),
    .WrEn   (WrEn),
    .Hazard (Hazard)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          r0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          hold;
    logic [AW-1:0] ard1;
    logic [AW-1:0] ard2;
    logic          e_ack0;
    logic          e_ack1;
    logic          e_wren;
    logic [AW-1:0] e_awr;
    logic [DW-1:0] e_din;
    logic          e_haz;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic hold, input logic [AW-1:0] ard1, input logic [AW-1:0] ard2,
    input logic e_ack0, input logic e_ack1,
    input logic e_wren, input logic [AW-1:0] e_awr, input logic [DW-1:0] e_din,
    input logic e_haz);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.d1 = d1;
    v.hold = hold; v.ard1 = ard1; v.ard2 = ard2;
    v.e_ack0 = e_ack0; v.e_ack1 = e_ack1;
    v.e_wren = e_wren; v.e_awr = e_awr; v.e_din = e_din;
    v.e_haz = e_haz;
    return v;
  endfunction

  task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic hold, input logic [AW-1:0] ard1, input logic [AW-1:0] ard2);
    Req0 = r0; Addr0 = a0; Data0 = d0;
    Req1 = r1; Addr1 = a1; Data1 = d1;
    Hold = hold; Ard1 = ard1; Ard2 = ard2;
  endtask

  // Behavioural model state for the randomized run.
  logic          m_valid;
  logic [AW-1:0] m_awr;
  logic [DW-1:0] m_din;
  int            m_fav;

  initial begin
    int            winner;
    logic          e_haz;
    logic [AW-1:0] inflight[$];

    // Reset with both requesters asking: outputs cleared, requester 0 favoured.
    Rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_wren", 32'(WrEn), 32'd0);
      check("rst_awr",  32'(Awr),  32'd0);
      check("rst_din",  Din,       32'd0);
      check("rst_ack0", 32'(Ack0), 32'd1);
      check("rst_ack1", 32'(Ack1), 32'd0);
      @(negedge Clk);
    end
    Rst_n = 1'b1;

    //            r0 a0     d0      r1 a1     d1      hd ard1   ard2   ak0 ak1 we  awr    din     hz
    tbl.push_back(mk(1, 5'd3,  32'hA,  1, 5'd4, 32'hB,  0, 5'd0,  5'd0,  1,  0,  0, 5'd0,  32'h0,  0));
    tbl.push_back(mk(1, 5'd3,  32'hA,  1, 5'd4, 32'hB,  0, 5'd0,  5'd0,  0,  1,  1, 5'd3,  32'hA,  0));
    tbl.push_back(mk(1, 5'd3,  32'hA,  1, 5'd4, 32'hB,  0, 5'd0,  5'd0,  1,  0,  1, 5'd4,  32'hB,  0));
    tbl.push_back(mk(1, 5'd3,  32'hA,  1, 5'd4, 32'hB,  0, 5'd0,  5'd0,  0,  1,  1, 5'd3,  32'hA,  0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd0,  5'd0,  0,  0,  1, 5'd4,  32'hB,  0));
    tbl.push_back(mk(1, 5'd15, 32'd22, 0, 5'd0, 32'h0,  0, 5'd0,  5'd0,  1,  0,  0, 5'd4,  32'hB,  0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd15, 5'd0,  0,  0,  1, 5'd15, 32'd22, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd15, 5'd0,  0,  0,  0, 5'd15, 32'd22, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  1, 5'd6, 32'h66, 1, 5'd0,  5'd0,  0,  0,  0, 5'd15, 32'd22, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  1, 5'd6, 32'h66, 1, 5'd0,  5'd0,  0,  0,  0, 5'd15, 32'd22, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  1, 5'd6, 32'h66, 1, 5'd0,  5'd0,  0,  0,  0, 5'd15, 32'd22, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  1, 5'd6, 32'h66, 0, 5'd0,  5'd0,  0,  1,  0, 5'd15, 32'd22, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd0,  5'd0,  0,  0,  1, 5'd6,  32'h66, 0));
    tbl.push_back(mk(1, 5'd7,  32'h77, 0, 5'd0, 32'h0,  1, 5'd7,  5'd0,  0,  0,  0, 5'd6,  32'h66, 1));
    tbl.push_back(mk(1, 5'd7,  32'h77, 0, 5'd0, 32'h0,  0, 5'd7,  5'd0,  1,  0,  0, 5'd6,  32'h66, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd7,  5'd0,  0,  0,  1, 5'd7,  32'h77, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd7,  5'd0,  0,  0,  0, 5'd7,  32'h77, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd0,  5'd7,  0,  0,  0, 5'd7,  32'h77, 0));
    tbl.push_back(mk(1, 5'd9,  32'h90, 1, 5'd9, 32'h91, 0, 5'd0,  5'd0,  0,  1,  0, 5'd7,  32'h77, 0));
    tbl.push_back(mk(1, 5'd9,  32'h90, 1, 5'd9, 32'h91, 0, 5'd0,  5'd0,  1,  0,  1, 5'd9,  32'h91, 0));
    tbl.push_back(mk(1, 5'd9,  32'h90, 0, 5'd0, 32'h0,  1, 5'd0,  5'd0,  0,  0,  1, 5'd9,  32'h90, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd0,  5'd0,  0,  0,  0, 5'd9,  32'h90, 0));
    tbl.push_back(mk(0, 5'd0,  32'h0,  1, 5'd0, 32'h5,  0, 5'd0,  5'd0,  0,  1,  0, 5'd9,  32'h90, 1));
    tbl.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0,  0, 5'd0,  5'd0,  0,  0,  1, 5'd0,  32'h5,  1));

    foreach (tbl[i]) begin
      drive(tbl[i].r0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].a1, tbl[i].d1,
            tbl[i].hold, tbl[i].ard1, tbl[i].ard2);
      #1;
      check($sformatf("v%0d_ack0", i), 32'(Ack0),   32'(tbl[i].e_ack0));
      check($sformatf("v%0d_ack1", i), 32'(Ack1),   32'(tbl[i].e_ack1));
      check($sformatf("v%0d_wren", i), 32'(WrEn),   32'(tbl[i].e_wren));
      check($sformatf("v%0d_awr",  i), 32'(Awr),    32'(tbl[i].e_awr));
      check($sformatf("v%0d_din",  i), Din,         tbl[i].e_din);
      check($sformatf("v%0d_haz",  i), 32'(Hazard), 32'(tbl[i].e_haz));
      @(negedge Clk);
    end

    // Asynchronous reset while a write to register 9 is on the port.
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    #1;
    check("mid_ack0", 32'(Ack0), 32'd1);
    @(posedge Clk);
    #2;
    check("mid_wren_before", 32'(WrEn), 32'd1);
    check("mid_awr_before",  32'(Awr),  32'd9);
    drive(1'b1, 5'h11, 32'h11, 1'b1, 5'h12, 32'h12, 1'b0, 5'd0, 5'd0);
    #1;
    Rst_n = 1'b0;
    #1;
    check("mid_wren_async", 32'(WrEn), 32'd0);
    check("mid_awr_async",  32'(Awr),  32'd0);
    check("mid_din_async",  Din,       32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("post_rst_ack0", 32'(Ack0), 32'd1);
    check("post_rst_ack1", 32'(Ack1), 32'd0);
    @(posedge Clk);
    #1;
    check("post_rst_wren", 32'(WrEn), 32'd1);
    check("post_rst_awr",  32'(Awr),  32'h11);

    // Randomized run against the behavioural model, from a fresh reset.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    m_valid = 1'b0;
    m_awr   = '0;
    m_din   = '0;
    m_fav   = 0;
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 3) == 0),
            AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));

      winner = -1;
      if (!Hold) begin
        if (Req0 && Req1) winner = m_fav;
        else if (Req0)    winner = 0;
        else if (Req1)    winner = 1;
      end

      inflight.delete();
      if (m_valid) inflight.push_back(m_awr);
      if (Req0)    inflight.push_back(Addr0);
      if (Req1)    inflight.push_back(Addr1);
      e_haz = 1'b0;
      foreach (inflight[k]) if (inflight[k] == Ard1 || inflight[k] == Ard2) e_haz = 1'b1;

      #1;
      check("rnd_ack0", 32'(Ack0),   32'(winner == 0));
      check("rnd_ack1", 32'(Ack1),   32'(winner == 1));
      check("rnd_wren", 32'(WrEn),   32'(m_valid));
      check("rnd_awr",  32'(Awr),    32'(m_awr));
      check("rnd_din",  Din,         m_din);
      check("rnd_haz",  32'(Hazard), 32'(e_haz));

      // Effect of the coming rising edge.
      m_valid = (winner >= 0);
      if (winner == 0) begin
        m_awr = Addr0; m_din = Data0; m_fav = 1;
      end else if (winner == 1) begin
        m_awr = Addr1; m_din = Data1; m_fav = 0;
      end
      @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
